// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the main-memory port arbiter.
// Holds the FSM state encoding, requester indices, default line size
// and the line-offset helper used to form beat addresses.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        DONE    = 2'd3
    } arb_state_t;

    localparam logic REQ_I = 1'b0;
    localparam logic REQ_D = 1'b1;

    localparam int LINE_WORDS_DEF = 32'sd8;

    // Number of byte-address bits below the line number.
    function automatic int line_off_w(input int line_words);
        return $clog2(line_words) + 32'sd2;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_line_beat_counter.sv
// Beat counter for one line burst: clears at grant, steps on each accepted
// beat and saturates at the last beat so it never wraps.
module line_beat_counter
    import mem_arb_pkg::*;
#(
    parameter int LINE_WORDS = LINE_WORDS_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clr,
    input  logic                          inc,
    output logic [$clog2(LINE_WORDS)-1:0] beat,
    output logic                          last
);

    localparam int BEAT_W = $clog2(LINE_WORDS);
    localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(LINE_WORDS - 1);

    assign last = (beat == BEAT_MAX);

    // Beat register: clear has priority, increment saturates at the last beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat <= '0;
        end else if (clr) begin
            beat <= '0;
        end else if (inc && !last) begin
            beat <= beat + {{(BEAT_W-1){1'b0}}, 1'b1};
        end else begin
            beat <= beat;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter sharing the main-memory port between icache and
// dcache. Grants one requester, latches its line address and op, and runs a
// LINE_WORDS-beat burst, returning per-beat valids and a done pulse.
// Optional macro ARB_ROUND_ROBIN_EN: alternate ties between requesters;
// without it the dcache always wins a tie.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LINE_WORDS = LINE_WORDS_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_read,
    input  logic [ADDR_W-1:0]             i_addr,
    output logic                          i_rvalid,
    output logic                          i_done,
    input  logic                          d_read,
    input  logic                          d_write,
    input  logic [ADDR_W-1:0]             d_addr,
    input  logic [DATA_W-1:0]             d_wdata,
    output logic                          d_rvalid,
    output logic                          d_done,
    output logic [DATA_W-1:0]             rdata,
    output logic [$clog2(LINE_WORDS)-1:0] beat_idx,
    output logic [1:0]                    grant,
    output logic                          mem_read,
    output logic                          mem_write,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_wdata,
    input  logic [DATA_W-1:0]             mem_rdata,
    input  logic                          mem_ack
);

    localparam int BEAT_W = $clog2(LINE_WORDS);
    localparam int OFF    = line_off_w(LINE_WORDS);
    localparam int LINE_W = ADDR_W - OFF;

    arb_state_t        state_r, state_nxt_s;
    logic [LINE_W-1:0] line_r, line_nxt_s;
    logic              wr_r, wr_nxt_s;
    logic              sel_d_r, sel_d_nxt_s;
    logic              d_req_s, any_req_s, pick_d_s;
    logic              serving_s, beat_clr_s, beat_inc_s, beat_last_s;
    logic [BEAT_W-1:0] beat_s;
    logic [ADDR_W-1:0] beat_addr_s;

    assign d_req_s   = d_read | d_write;
    assign any_req_s = i_read | d_req_s;
    assign serving_s = (state_r == SERVE_I) || (state_r == SERVE_D);

`ifdef ARB_ROUND_ROBIN_EN
    logic last_grant_r;

    // Remember who was granted last so a tie goes to the other requester.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_r <= REQ_I;
        end else if ((state_r == IDLE) && any_req_s) begin
            last_grant_r <= pick_d_s ? REQ_D : REQ_I;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end

    assign pick_d_s = d_req_s && (!i_read || (last_grant_r == REQ_I));
`else
    assign pick_d_s = d_req_s;
`endif

    line_beat_counter #(.LINE_WORDS(LINE_WORDS)) u_beat (
        .clk  (clk),
        .rst  (rst),
        .clr  (beat_clr_s),
        .inc  (beat_inc_s),
        .beat (beat_s),
        .last (beat_last_s)
    );

    assign beat_inc_s  = serving_s && mem_ack;
    assign beat_addr_s = {line_r, beat_s, 2'b00};
    assign beat_idx    = beat_s;
    assign rdata       = mem_rdata;

    // Next-state logic: arbitrate in IDLE, count beats while serving.
    always_comb begin
        state_nxt_s = state_r;
        line_nxt_s  = line_r;
        wr_nxt_s    = wr_r;
        sel_d_nxt_s = sel_d_r;
        beat_clr_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (any_req_s) begin
                    beat_clr_s  = 1'b1;
                    sel_d_nxt_s = pick_d_s;
                    if (pick_d_s) begin
                        state_nxt_s = SERVE_D;
                        line_nxt_s  = d_addr[ADDR_W-1:OFF];
                        wr_nxt_s    = d_write;
                    end else begin
                        state_nxt_s = SERVE_I;
                        line_nxt_s  = i_addr[ADDR_W-1:OFF];
                        wr_nxt_s    = 1'b0;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SERVE_I, SERVE_D: begin
                if (mem_ack && beat_last_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State, latched line address, op and served requester.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            line_r  <= '0;
            wr_r    <= 1'b0;
            sel_d_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            line_r  <= line_nxt_s;
            wr_r    <= wr_nxt_s;
            sel_d_r <= sel_d_nxt_s;
        end
    end

    // Output decode: strobes and grant from state, valids straight from ack.
    always_comb begin
        grant     = 2'b00;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        i_rvalid  = 1'b0;
        d_rvalid  = 1'b0;
        i_done    = 1'b0;
        d_done    = 1'b0;
        case (state_r)
            SERVE_I: begin
                grant[REQ_I] = 1'b1;
                mem_read     = 1'b1;
                mem_addr     = beat_addr_s;
                i_rvalid     = mem_ack;
            end
            SERVE_D: begin
                grant[REQ_D] = 1'b1;
                mem_read     = !wr_r;
                mem_write    = wr_r;
                mem_addr     = beat_addr_s;
                d_rvalid     = mem_ack;
                if (wr_r) begin
                    mem_wdata = d_wdata;
                end else begin
                    mem_wdata = '0;
                end
            end
            DONE: begin
                if (sel_d_r) begin
                    d_done = 1'b1;
                end else begin
                    i_done = 1'b1;
                end
            end
            IDLE:    grant = 2'b00;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with an address/wdata scoreboard.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_read, i_rvalid, i_done;
    logic [31:0] i_addr;
    logic        d_read, d_write, d_rvalid, d_done;
    logic [31:0] d_addr, d_wdata, rdata;
    logic [2:0]  beat_idx;
    logic [1:0]  grant;
    logic        mem_read, mem_write, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   n_fail  = 0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LINE_WORDS(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_read    (i_read),
        .i_addr    (i_addr),
        .i_rvalid  (i_rvalid),
        .i_done    (i_done),
        .d_read    (d_read),
        .d_write   (d_write),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rvalid  (d_rvalid),
        .d_done    (d_done),
        .rdata     (rdata),
        .beat_idx  (beat_idx),
        .grant     (grant),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one burst from IDLE (request already driven) through DONE back to IDLE.
    task automatic burst(input bit is_d, input bit wr, input logic [31:0] line,
                         input int period, input bit drop_all,
                         input int mid_i_beat, input logic [31:0] mid_i_addr,
                         input string tag);
        exp_t        e;
        int          beats;
        bit          done;
        logic [1:0]  exp_grant;
        logic [2:0]  kk;
        beats     = 0;
        done      = 1'b0;
        exp_grant = is_d ? 2'b10 : 2'b01;
        exp_q.delete();
        for (int k = 0; k < 8; k++) begin
            kk      = k[2:0];
            e.addr  = {line[31:5], kk, 2'b00};
            e.wdata = 32'hC0DE_0000 | 32'(k);
            exp_q.push_back(e);
        end
        tick();
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            mem_ack   = ((cyc % period) == (period - 1));
            mem_rdata = 32'h5A00_0000 + 32'(cyc);
            d_wdata   = 32'hC0DE_0000 | 32'(beat_idx);
            if (cyc == 0) begin
                if (is_d) d_addr = ~line;
                else      i_addr = ~line;
            end
            if (mid_i_beat >= 0 && beats == mid_i_beat) begin
                i_read = 1'b1;
                i_addr = mid_i_addr;
            end
            #1;
            chk({tag, ":grant"}, 64'(grant), 64'(exp_grant));
            chk({tag, ":mem_read"}, 64'(mem_read), 64'(!wr));
            chk({tag, ":mem_write"}, 64'(mem_write), 64'(wr));
            chk({tag, ":mem_addr"}, 64'(mem_addr), 64'(exp_q[0].addr));
            chk({tag, ":rvalid"}, 64'({d_rvalid, i_rvalid}),
                64'(mem_ack ? exp_grant : 2'b00));
            chk({tag, ":no_early_done"}, 64'({d_done, i_done}), 64'(0));
            if (mem_ack) begin
                chk({tag, ":rdata"}, 64'(rdata), 64'(mem_rdata));
                if (wr) chk({tag, ":mem_wdata"}, 64'(mem_wdata), 64'(exp_q[0].wdata));
                void'(exp_q.pop_front());
                beats++;
            end
            if (exp_q.size() == 0) done = 1'b1;
            tick();
        end
        mem_ack = 1'b0;
        #1;
        chk({tag, ":finished"}, 64'(done), 64'(1));
        chk({tag, ":beats"}, 64'(beats), 64'(8));
        chk({tag, ":done"}, 64'({d_done, i_done}), 64'(exp_grant));
        chk({tag, ":done_grant"}, 64'(grant), 64'(0));
        chk({tag, ":done_strobes"}, 64'({mem_read, mem_write}), 64'(0));
        if (is_d || drop_all) begin
            d_read  = 1'b0;
            d_write = 1'b0;
        end
        if (!is_d || drop_all) i_read = 1'b0;
        tick();
        chk({tag, ":idle_done"}, 64'({d_done, i_done}), 64'(0));
        chk({tag, ":idle_grant"}, 64'(grant), 64'(0));
    endtask

    initial begin
        rst = 1'b1;
        i_read = 1'b0; i_addr = 32'h0; d_read = 1'b0; d_write = 1'b0;
        d_addr = 32'h0; d_wdata = 32'h0; mem_rdata = 32'h0; mem_ack = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("reset:grant", 64'(grant), 64'(0));
        chk("reset:strobes", 64'({mem_read, mem_write}), 64'(0));
        chk("reset:mem_addr", 64'(mem_addr), 64'(0));
        chk("reset:beat", 64'(beat_idx), 64'(0));
        chk("reset:done", 64'({d_done, i_done}), 64'(0));

        // Single icache fill, ack every cycle.
        i_read = 1'b1; i_addr = 32'h0000_1234;
        burst(1'b0, 1'b0, 32'h0000_1234, 1, 1'b1, -1, 32'h0, "ifill");

        // Dcache writeback with ack every third cycle.
        d_write = 1'b1; d_addr = 32'h0000_0080;
        burst(1'b1, 1'b1, 32'h0000_0080, 3, 1'b1, -1, 32'h0, "dwb");

        // Icache request raised during beat 3 of a dcache read.
        d_read = 1'b1; d_addr = 32'h0000_0500;
        burst(1'b1, 1'b0, 32'h0000_0500, 1, 1'b0, 3, 32'h0000_4000, "dread_mid");
        chk("mid:i_still_req_idle", 64'(grant), 64'(0));
        burst(1'b0, 1'b0, 32'h0000_4000, 1, 1'b1, -1, 32'h0, "ifill_after");

        // Reset mid-burst at beat 4.
        d_read = 1'b1; d_addr = 32'h0000_0300; mem_ack = 1'b1;
        tick();
        repeat (4) tick();
        chk("rstmid:beat4", 64'(beat_idx), 64'(4));
        rst = 1'b1;
        tick();
        chk("rstmid:grant", 64'(grant), 64'(0));
        chk("rstmid:strobes", 64'({mem_read, mem_write}), 64'(0));
        chk("rstmid:beat", 64'(beat_idx), 64'(0));
        chk("rstmid:done", 64'({d_done, i_done}), 64'(0));
        rst = 1'b0; mem_ack = 1'b0; d_addr = 32'h0000_0340;
        burst(1'b1, 1'b0, 32'h0000_0340, 1, 1'b1, -1, 32'h0, "restart");

        // Ties in IDLE, starting from a fresh reset.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        i_read = 1'b1; d_read = 1'b1; i_addr = 32'h0000_1000; d_addr = 32'h0000_2000;
        burst(1'b1, 1'b0, 32'h0000_2000, 1, 1'b1, -1, 32'h0, "tie1");
        i_read = 1'b1; d_read = 1'b1; i_addr = 32'h0000_1100; d_addr = 32'h0000_2100;
`ifdef ARB_ROUND_ROBIN_EN
        burst(1'b0, 1'b0, 32'h0000_1100, 1, 1'b1, -1, 32'h0, "tie2");
`else
        burst(1'b1, 1'b0, 32'h0000_2100, 1, 1'b1, -1, 32'h0, "tie2");
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
